alu_uart_ctrl: RTL and testbench

Sequencer between the UART receiver/transmitter and the combinational ALU.
- Collects three bytes from the receiver in order: operand A, operand B, opcode.
- Presents them as registered operands to the ALU and latches the ALU result.
- Hands the result to the transmitter, waits for completion, then re-arms.
- Sits in the top level between uart_rx, alu and uart_tx, all on one clock.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_uart_ctrl_if.sv | 36 +++
 rtl/alu_uart_ctrl_frame_timeout_cnt.sv | 39 +++
 rtl/alu_uart_ctrl.sv | 168 ++++++++++++++++
 tb/tb_alu_uart_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, controller state encoding,
// default widths and the supported-opcode check.
package alu_pkg;

  localparam int NB_DATA_DEF   = 8;
  localparam int NB_OPCODE_DEF = 6;

  localparam logic [NB_OPCODE_DEF-1:0] OP_ADD = 6'h20;
  localparam logic [NB_OPCODE_DEF-1:0] OP_SUB = 6'h22;
  localparam logic [NB_OPCODE_DEF-1:0] OP_AND = 6'h24;
  localparam logic [NB_OPCODE_DEF-1:0] OP_OR  = 6'h25;
  localparam logic [NB_OPCODE_DEF-1:0] OP_XOR = 6'h26;
  localparam logic [NB_OPCODE_DEF-1:0] OP_SRA = 6'h03;
  localparam logic [NB_OPCODE_DEF-1:0] OP_SRL = 6'h02;
  localparam logic [NB_OPCODE_DEF-1:0] OP_NOR = 6'h27;

  typedef enum logic [2:0] {
    ST_WAIT_A  = 3'd0,
    ST_WAIT_B  = 3'd1,
    ST_WAIT_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } ctrl_state_e;

  // Zero-extended opcode so any NB_OPCODE width can be checked.
  function automatic logic is_valid_opcode(input logic [31:0] op);
    return op inside {32'(OP_ADD), 32'(OP_SUB), 32'(OP_AND), 32'(OP_OR),
                      32'(OP_XOR), 32'(OP_SRA), 32'(OP_SRL), 32'(OP_NOR)};
  endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Bus between the ALU/UART sequencer and its surroundings (uart_rx, uart_tx, alu).
// master = the sequencer, slave = the environment driving the UART/ALU side.
interface alu_uart_ctrl_if
  import alu_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_OPCODE = NB_OPCODE_DEF
);

  logic [NB_DATA-1:0]   i_rx_data;
  logic                 i_rx_done;
  logic                 i_tx_done;
  logic [NB_DATA-1:0]   i_alu_result;
  logic [NB_DATA-1:0]   o_op_A;
  logic [NB_DATA-1:0]   o_op_B;
  logic [NB_OPCODE-1:0] o_opcode;
  logic [NB_DATA-1:0]   o_tx_data;
  logic                 o_tx_start;
  logic                 o_busy;
  logic                 o_invalid;
  logic                 o_timeout;
  logic                 o_overrun;

  modport master (
    input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    output o_op_A, o_op_B, o_opcode, o_tx_data, o_tx_start,
           o_busy, o_invalid, o_timeout, o_overrun
  );

  modport slave (
    output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
    input  o_op_A, o_op_B, o_opcode, o_tx_data, o_tx_start,
           o_busy, o_invalid, o_timeout, o_overrun
  );

endinterface

// File: rtl/alu_uart_ctrl_frame_timeout_cnt.sv
// Inter-byte idle counter for a partially received frame. expiry is raised in
// the cycle whose closing edge would bring the count to TIMEOUT_CYCLES-1.
module frame_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic enable,
  input  logic clear,
  output logic expiry
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign expiry = 1'b0;
    end else begin : g_counter
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

      logic [CNT_W-1:0] cnt_r;

      assign expiry = enable &&
                      ((32'(cnt_r) + 32'd1) >= 32'(TIMEOUT_CYCLES - 1));

      // idle-cycle counter, held at expiry until the frame is dropped
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          cnt_r <= '0;
        end else if (clear) begin
          cnt_r <= '0;
        end else if (enable && !expiry) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end else begin
          cnt_r <= cnt_r;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between uart_rx, the combinational alu and uart_tx: gathers A, B and
// opcode bytes, latches the ALU result and hands it to the transmitter.
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEF,
  parameter int NB_OPCODE      = NB_OPCODE_DEF,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic             i_clk,
  input logic             i_rst_n,
  alu_uart_ctrl_if.master bus
);

  ctrl_state_e state_r;
  ctrl_state_e state_next_s;

  logic capture_a_s;
  logic capture_b_s;
  logic capture_op_s;
  logic exec_s;
  logic timeout_fire_s;
  logic overrun_set_s;
  logic tmo_en_s;
  logic tmo_clr_s;
  logic tmo_expiry_s;

  logic [NB_DATA-1:0]   op_a_r;
  logic [NB_DATA-1:0]   op_b_r;
  logic [NB_OPCODE-1:0] opcode_r;
  logic [NB_DATA-1:0]   tx_data_r;
  logic                 tx_start_r;
  logic                 busy_r;
  logic                 invalid_r;
  logic                 timeout_r;
  logic                 overrun_r;

  assign tmo_en_s  = (state_r == ST_WAIT_B) || (state_r == ST_WAIT_OP);
  assign tmo_clr_s = bus.i_rx_done || !tmo_en_s;

  frame_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_timeout_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .enable  (tmo_en_s),
    .clear   (tmo_clr_s),
    .expiry  (tmo_expiry_s)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= ST_WAIT_A;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next state and per-cycle strobes; a byte in the expiry cycle wins over the timeout
  always_comb begin
    state_next_s   = state_r;
    capture_a_s    = 1'b0;
    capture_b_s    = 1'b0;
    capture_op_s   = 1'b0;
    exec_s         = 1'b0;
    timeout_fire_s = 1'b0;
    overrun_set_s  = 1'b0;
    case (state_r)
      ST_WAIT_A: begin
        if (bus.i_rx_done) begin
          capture_a_s  = 1'b1;
          state_next_s = ST_WAIT_B;
        end else begin
          state_next_s = ST_WAIT_A;
        end
      end
      ST_WAIT_B: begin
        if (bus.i_rx_done) begin
          capture_b_s  = 1'b1;
          state_next_s = ST_WAIT_OP;
        end else if (tmo_expiry_s) begin
          timeout_fire_s = 1'b1;
          state_next_s   = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_B;
        end
      end
      ST_WAIT_OP: begin
        if (bus.i_rx_done) begin
          capture_op_s = 1'b1;
          state_next_s = ST_EXEC;
        end else if (tmo_expiry_s) begin
          timeout_fire_s = 1'b1;
          state_next_s   = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_OP;
        end
      end
      ST_EXEC: begin
        exec_s        = 1'b1;
        overrun_set_s = bus.i_rx_done;
        state_next_s  = ST_SEND;
      end
      ST_SEND: begin
        overrun_set_s = bus.i_rx_done;
        state_next_s  = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        overrun_set_s = bus.i_rx_done;
        if (bus.i_tx_done) begin
          state_next_s = ST_WAIT_A;
        end else begin
          state_next_s = ST_WAIT_TX;
        end
      end
      default: begin
        state_next_s = ST_WAIT_A;
      end
    endcase
  end

  // operand capture, result latch and status outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_a_r     <= '0;
      op_b_r     <= '0;
      opcode_r   <= '0;
      tx_data_r  <= '0;
      tx_start_r <= 1'b0;
      busy_r     <= 1'b0;
      invalid_r  <= 1'b0;
      timeout_r  <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      if (capture_a_s) begin
        op_a_r <= bus.i_rx_data;
      end
      if (capture_b_s) begin
        op_b_r <= bus.i_rx_data;
      end
      if (capture_op_s) begin
        opcode_r <= bus.i_rx_data[NB_OPCODE-1:0];
      end
      if (exec_s) begin
        tx_data_r <= bus.i_alu_result;
        invalid_r <= !is_valid_opcode(32'(opcode_r));
      end
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end
      tx_start_r <= (state_next_s == ST_SEND);
      busy_r     <= state_next_s inside {ST_EXEC, ST_SEND, ST_WAIT_TX};
      timeout_r  <= timeout_fire_s;
    end
  end

  assign bus.o_op_A     = op_a_r;
  assign bus.o_op_B     = op_b_r;
  assign bus.o_opcode   = opcode_r;
  assign bus.o_tx_data  = tx_data_r;
  assign bus.o_tx_start = tx_start_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_invalid  = invalid_r;
  assign bus.o_timeout  = timeout_r;
  assign bus.o_overrun  = overrun_r;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Self-checking bench for alu_uart_ctrl: directed frames, timeout timing,
// overrun and reset, plus randomized frames against a behavioural ALU model.
module tb_alu_uart_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic exp_overrun;

  alu_uart_ctrl_if #(.NB_DATA(8), .NB_OPCODE(6)) bus ();

  alu_uart_ctrl #(
    .NB_DATA        (8),
    .NB_OPCODE      (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   alu_ref = a + b;
      6'h22:   alu_ref = a - b;
      6'h24:   alu_ref = a & b;
      6'h25:   alu_ref = a | b;
      6'h26:   alu_ref = a ^ b;
      6'h03:   alu_ref = 8'($signed(a) >>> b);
      6'h02:   alu_ref = a >> b;
      6'h27:   alu_ref = ~(a | b);
      default: alu_ref = 8'h00;
    endcase
  endfunction

  assign bus.i_alu_result = alu_ref(bus.o_op_A, bus.o_op_B, bus.o_opcode);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Caller sits at a negedge; leaves at the negedge after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    bus.i_rx_data = b;
    bus.i_rx_done = 1'b1;
    @(negedge clk);
    bus.i_rx_done = 1'b0;
    bus.i_rx_data = 8'h00;
  endtask

  task automatic idle(input int n, input bit noise);
    repeat (n) begin
      bus.i_tx_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.i_tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_op_a"},    32'(bus.o_op_A),     32'd0);
    check_val({tag, "_op_b"},    32'(bus.o_op_B),     32'd0);
    check_val({tag, "_opcode"},  32'(bus.o_opcode),   32'd0);
    check_val({tag, "_tx_data"}, 32'(bus.o_tx_data),  32'd0);
    check_val({tag, "_start"},   32'(bus.o_tx_start), 32'd0);
    check_val({tag, "_busy"},    32'(bus.o_busy),     32'd0);
    check_val({tag, "_invalid"}, 32'(bus.o_invalid),  32'd0);
    check_val({tag, "_timeout"}, 32'(bus.o_timeout),  32'd0);
    check_val({tag, "_overrun"}, 32'(bus.o_overrun),  32'd0);
  endtask

  // Called right after the opcode byte: state is EXEC.
  task automatic finish_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input logic [7:0] exp_res, input logic exp_inv,
                              input bit inject_ovr, input int gap);
    check_val("exec_busy",  32'(bus.o_busy),     32'd1);
    check_val("exec_start", 32'(bus.o_tx_start), 32'd0);
    @(negedge clk);
    check_val("send_start", 32'(bus.o_tx_start), 32'd1);
    check_val("tx_data",    32'(bus.o_tx_data),  32'(exp_res));
    check_val("invalid",    32'(bus.o_invalid),  32'(exp_inv));
    check_val("op_a",       32'(bus.o_op_A),     32'(a));
    check_val("op_b",       32'(bus.o_op_B),     32'(b));
    check_val("opcode",     32'(bus.o_opcode),   32'(opb[5:0]));
    @(negedge clk);
    check_val("start_pulse", 32'(bus.o_tx_start), 32'd0);
    check_val("wtx_busy",    32'(bus.o_busy),     32'd1);
    if (inject_ovr) begin
      send_byte(8'hAA);
      exp_overrun = 1'b1;
      check_val("ovr_flag",    32'(bus.o_overrun), 32'd1);
      check_val("ovr_tx_data", 32'(bus.o_tx_data), 32'(exp_res));
      check_val("ovr_op_a",    32'(bus.o_op_A),    32'(a));
      check_val("ovr_busy",    32'(bus.o_busy),    32'd1);
    end
    idle(gap, 1'b0);
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
    check_val("done_busy",    32'(bus.o_busy),     32'd0);
    check_val("done_tx_hold", 32'(bus.o_tx_data),  32'(exp_res));
    check_val("done_overrun", 32'(bus.o_overrun),  32'(exp_overrun));
    check_val("done_timeout", 32'(bus.o_timeout),  32'd0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input logic [7:0] exp_res, input logic exp_inv, input int gap);
    send_byte(a);
    idle(gap, 1'b1);
    send_byte(b);
    idle(gap, 1'b1);
    send_byte(opb);
    finish_frame(a, b, opb, exp_res, exp_inv, 1'b0, gap);
  endtask

  initial begin
    logic [7:0] valid_ops [8];
    logic [7:0] ra, rb, rop;
    logic       rinv;

    valid_ops = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h03, 8'h02, 8'h27};
    checks = 0;
    failures = 0;
    exp_overrun = 1'b0;
    rst_n = 1'b0;
    bus.i_rx_data = 8'h00;
    bus.i_rx_done = 1'b0;
    bus.i_tx_done = 1'b0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed frames, back to back
    run_frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b0, 0);
    run_frame(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0, 0);
    run_frame(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0, 0);
    run_frame(8'h80, 8'h02, 8'h02, 8'h20, 8'h0 == 8'h1, 1);
    run_frame(8'h12, 8'h34, 8'h3F, 8'h00, 1'b1, 2);
    run_frame(8'h01, 8'h01, 8'h20, 8'h02, 1'b0, 1);

    // silence after byte A: timeout pulses 15 cycles after entering WAIT_B
    send_byte(8'h05);
    for (int i = 0; i < 15; i++) begin
      check_val("tmo_early", 32'(bus.o_timeout), 32'd0);
      @(negedge clk);
    end
    check_val("tmo_pulse", 32'(bus.o_timeout), 32'd1);
    check_val("tmo_busy",  32'(bus.o_busy),    32'd0);
    check_val("tmo_op_a",  32'(bus.o_op_A),    32'h05);
    @(negedge clk);
    check_val("tmo_one_cycle", 32'(bus.o_timeout), 32'd0);
    run_frame(8'h07, 8'h01, 8'h22, 8'h06, 1'b0, 1);

    // byte B lands exactly in the expiry cycle: accepted, no timeout
    send_byte(8'h10);
    idle(14, 1'b0);
    send_byte(8'h20);
    check_val("edge_no_tmo", 32'(bus.o_timeout), 32'd0);
    check_val("edge_op_b",   32'(bus.o_op_B),    32'h20);
    @(negedge clk);
    check_val("edge_no_tmo2", 32'(bus.o_timeout), 32'd0);
    send_byte(8'h20);
    finish_frame(8'h10, 8'h20, 8'h20, 8'h30, 1'b0, 1'b0, 0);

    // byte during WAIT_TX is dropped and flags overrun
    send_byte(8'h0F);
    send_byte(8'h3C);
    send_byte(8'h26);
    finish_frame(8'h0F, 8'h3C, 8'h26, 8'h33, 1'b0, 1'b1, 2);

    // randomized frames
    for (int n = 0; n < 30; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom_range(0, 9));
      if ($urandom_range(0, 3) != 0) begin
        rop = valid_ops[$urandom_range(0, 7)] | {2'($urandom_range(0, 3)), 6'h00};
      end else begin
        rop = 8'($urandom);
      end
      rinv = !(rop[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h03, 6'h02, 6'h27});
      run_frame(ra, rb, rop, alu_ref(ra, rb, rop[5:0]), rinv, $urandom_range(0, 4));
    end

    // reset in WAIT_OP clears everything, including sticky overrun
    send_byte(8'h44);
    send_byte(8'h55);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_overrun = 1'b0;
    check_all_zero("midrst");
    run_frame(8'h0C, 8'h0A, 8'h24, 8'h08, 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
